// File: rtl/rf_arb_pkg.sv
// Shared types and helpers for the register-file access arbiter.
package rf_arb_pkg;

    typedef enum logic {
        REQ_P0 = 1'b0,
        REQ_P1 = 1'b1
    } req_id_t;

    localparam int NUM_REQ = 2;

    // Map a one-hot grant vector to the requester it names (P0 when idle).
    function automatic req_id_t gnt_to_id(input logic [NUM_REQ-1:0] gnt);
        req_id_t id;
        if (gnt[1]) begin
            id = REQ_P1;
        end else begin
            id = REQ_P0;
        end
        return id;
    endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter. The grant is combinational from the
// requests and the pointer. The pointer names the requester that wins a tie.
module rr_arbiter_2
    import rf_arb_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_REQ-1:0] req_i,
    output logic [NUM_REQ-1:0] gnt_o
);

    req_id_t ptr_q;
    req_id_t ptr_d;

    // Grant selection: a single request wins outright, and the pointer breaks a tie.
    always_comb begin
        gnt_o = 2'b00;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11: begin
                if (ptr_q == REQ_P0) begin
                    gnt_o = 2'b01;
                end else begin
                    gnt_o = 2'b10;
                end
            end
            default: gnt_o = 2'b00;
        endcase
    end

    // Next pointer: after any grant, favour the requester that lost.
    always_comb begin
        ptr_d = ptr_q;
        if (gnt_o[0]) begin
            ptr_d = REQ_P1;
        end else if (gnt_o[1]) begin
            ptr_d = REQ_P0;
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register. Reset returns priority to P0.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= REQ_P0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/rf_access_arbiter.sv
// Shares one register file between two requesters. The write port and the
// read port are arbitrated separately, so a write and a read from different
// requesters can both complete in one cycle. Read data returns one cycle
// after acceptance. A write to the same address in the same cycle is forwarded.
module rf_access_arbiter
    import rf_arb_pkg::*;
#(
    parameter int ADDR_WIDTH_RF = 4,
    parameter int DATA_WIDTH    = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     p0_req_valid,
    input  logic                     p0_req_write,
    input  logic [ADDR_WIDTH_RF-1:0] p0_req_addr,
    input  logic [DATA_WIDTH-1:0]    p0_req_wdata,
    output logic                     p0_req_ready,
    output logic                     p0_rsp_valid,
    output logic [DATA_WIDTH-1:0]    p0_rsp_rdata,
    input  logic                     p1_req_valid,
    input  logic                     p1_req_write,
    input  logic [ADDR_WIDTH_RF-1:0] p1_req_addr,
    input  logic [DATA_WIDTH-1:0]    p1_req_wdata,
    output logic                     p1_req_ready,
    output logic                     p1_rsp_valid,
    output logic [DATA_WIDTH-1:0]    p1_rsp_rdata,
    output logic                     rf_write_enable,
    output logic [ADDR_WIDTH_RF-1:0] rf_address_1,
    output logic [DATA_WIDTH-1:0]    rf_write_data,
    output logic [ADDR_WIDTH_RF-1:0] rf_address_2,
    input  logic [DATA_WIDTH-1:0]    rf_read_data
);

    logic [NUM_REQ-1:0]    wr_req_s;
    logic [NUM_REQ-1:0]    rd_req_s;
    logic [NUM_REQ-1:0]    wr_gnt_s;
    logic [NUM_REQ-1:0]    rd_gnt_s;
    logic [NUM_REQ-1:0]    wr_ok_s;
    logic [NUM_REQ-1:0]    rd_ok_s;
    req_id_t               rd_id_s;
    logic                  fwd_s;
    logic [DATA_WIDTH-1:0] rd_data_s;

    logic [NUM_REQ-1:0]    rsp_valid_q;
    logic [DATA_WIDTH-1:0] p0_rdata_q;
    logic [DATA_WIDTH-1:0] p1_rdata_q;

    // Each requester is either a write candidate or a read candidate in a given cycle.
    assign wr_req_s = {p1_req_valid &  p1_req_write, p0_req_valid &  p0_req_write};
    assign rd_req_s = {p1_req_valid & ~p1_req_write, p0_req_valid & ~p0_req_write};

    rr_arbiter_2 u_wr_arb (
        .clk_i (clk),
        .rst_i (reset),
        .req_i (wr_req_s),
        .gnt_o (wr_gnt_s)
    );

    rr_arbiter_2 u_rd_arb (
        .clk_i (clk),
        .rst_i (reset),
        .req_i (rd_req_s),
        .gnt_o (rd_gnt_s)
    );

    // Reset blocks every handshake, including one already in progress in the current cycle.
    assign wr_ok_s = wr_gnt_s & {NUM_REQ{~reset}};
    assign rd_ok_s = rd_gnt_s & {NUM_REQ{~reset}};

    assign p0_req_ready = wr_ok_s[0] | rd_ok_s[0];
    assign p1_req_ready = wr_ok_s[1] | rd_ok_s[1];

    // Write port mux: drive the winner's payload, or zeros when there is no winner.
    always_comb begin
        rf_write_enable = 1'b0;
        rf_address_1    = '0;
        rf_write_data   = '0;
        case (wr_ok_s)
            2'b01: begin
                rf_write_enable = 1'b1;
                rf_address_1    = p0_req_addr;
                rf_write_data   = p0_req_wdata;
            end
            2'b10: begin
                rf_write_enable = 1'b1;
                rf_address_1    = p1_req_addr;
                rf_write_data   = p1_req_wdata;
            end
            default: begin
                rf_write_enable = 1'b0;
                rf_address_1    = '0;
                rf_write_data   = '0;
            end
        endcase
    end

    assign rd_id_s = gnt_to_id(rd_ok_s);

    // Read port mux: drive the winner's address, or zero when the read port is idle.
    always_comb begin
        rf_address_2 = '0;
        if (rd_ok_s == 2'b00) begin
            rf_address_2 = '0;
        end else if (rd_id_s == REQ_P1) begin
            rf_address_2 = p1_req_addr;
        end else begin
            rf_address_2 = p0_req_addr;
        end
    end

    // The register file returns the old value during a same-address write,
    // so the new write data is used instead.
    assign fwd_s     = rf_write_enable && (rd_ok_s != 2'b00) && (rf_address_1 == rf_address_2);
    assign rd_data_s = fwd_s ? rf_write_data : rf_read_data;

    // Response registers: one valid pulse per accepted read. The data is held between reads.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid_q <= 2'b00;
            p0_rdata_q  <= '0;
            p1_rdata_q  <= '0;
        end else begin
            rsp_valid_q <= rd_ok_s;
            if (rd_ok_s[0]) begin
                p0_rdata_q <= rd_data_s;
            end
            if (rd_ok_s[1]) begin
                p1_rdata_q <= rd_data_s;
            end
        end
    end

    assign p0_rsp_valid = rsp_valid_q[0];
    assign p1_rsp_valid = rsp_valid_q[1];
    assign p0_rsp_rdata = p0_rdata_q;
    assign p1_rsp_rdata = p1_rdata_q;

endmodule
